// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg
//   Shared definitions for the partial-sum read-modify-write controller:
//   lane geometry (default lane width, lanes per word) and the controller
//   state encoding.
package psum_accumulator_pkg;

  localparam int unsigned MAC_OUTPUT_WIDTH = 36;
  localparam int unsigned LANES            = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
//   Data-path bundle of the accumulator: the MAC result stream in, the
//   buffer read port (adder_pulse / adder_feature) and the write-back port
//   (feature_in / feature_valid).
//   slave  : accumulator side (consumes MAC words, drives buffer ports)
//   master : environment side (MAC array + output buffer)
interface psum_accumulator_if
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned W = psum_accumulator_pkg::MAC_OUTPUT_WIDTH
);

  localparam int unsigned DW = W * LANES;

  logic [DW-1:0] mac_feature;
  logic          mac_valid;
  logic          mac_ready;
  logic          adder_pulse;
  logic [DW-1:0] adder_feature;
  logic [DW-1:0] feature_in;
  logic          feature_valid;

  modport slave (
    input  mac_feature, mac_valid, adder_feature,
    output mac_ready, adder_pulse, feature_in, feature_valid
  );

  modport master (
    output mac_feature, mac_valid, adder_feature,
    input  mac_ready, adder_pulse, feature_in, feature_valid
  );

endinterface

// File: rtl/psum_accumulator_lane_add.sv
// psum_lane_add
//   Combinational saturating add of two signed W-bit lanes.
//   a_i, b_i : signed operands
//   sum_o    : a_i + b_i clamped to [-2^(W-1), 2^(W-1)-1]
module psum_lane_add
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned W = psum_accumulator_pkg::MAC_OUTPUT_WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] sum;

  always_comb begin
    sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Overflow shows as the two top bits of the widened sum disagreeing;
    // the extra top bit then carries the true sign.
    if (sum[W] != sum[W-1]) begin
      sum_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = sum[W-1:0];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Read-modify-write controller between the MAC array and the output
//   partial-sum buffer. Prefetches buffer words ahead of demand into a small
//   FIFO, adds them lane-wise (saturating) to accepted MAC words and writes
//   the result back one cycle after acceptance.
//   system_clk  : clock
//   rst         : synchronous active-high reset
//   pass_start  : start pulse (honoured only in IDLE)
//   pass_len    : words in the pass (0 means 1), sampled on pass_start
//   first_pass  : write MAC data without reading the buffer
//   pass_busy   : pass in progress
//   pass_done   : one-cycle pulse after the last write-back
//   refresh_req : buffer pointer reset, same cycle as accepted pass_start
//   bus         : MAC stream, buffer read port and write-back port
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned MAC_OUTPUT_WIDTH = psum_accumulator_pkg::MAC_OUTPUT_WIDTH,
  parameter int unsigned RD_LATENCY       = 3,
  parameter int unsigned PF_DEPTH         = 8,
  parameter int unsigned LEN_WIDTH        = 15
) (
  input  logic                 system_clk,
  input  logic                 rst,
  input  logic                 pass_start,
  input  logic [LEN_WIDTH-1:0] pass_len,
  input  logic                 first_pass,
  output logic                 pass_busy,
  output logic                 pass_done,
  output logic                 refresh_req,
  psum_accumulator_if.slave    bus
);

  localparam int unsigned W     = MAC_OUTPUT_WIDTH;
  localparam int unsigned DW    = W * LANES;
  localparam int unsigned PTR_W = $clog2(PF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_e               state_q, state_d;
  logic                 flush_q, flush_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 first_q, first_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic [RD_LATENCY-1:0] sr_q, sr_d;

  logic [DW-1:0]        fifo_q [PF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     pf_count_q;

  logic [DW-1:0]        feat_q;
  logic                 fvalid_q;

  logic                 run, pulse, ready, accept, push, pop, credit_ok;
  logic                 refresh;
  logic [CNT_W-1:0]     inflight;
  logic [DW-1:0]        head, sum_word;

  assign run  = (state_q == ST_RUN);
  assign push = sr_q[RD_LATENCY-1];
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(sr_q[i]);
    end
  end

  // Reads still in flight already own a FIFO slot, so the FIFO cannot overflow.
  assign credit_ok = ({1'b0, inflight} + {1'b0, pf_count_q}) < (CNT_W+1)'(PF_DEPTH);
  assign pulse     = run && !first_q && (issued_q < len_q) && credit_ok;
  assign ready     = run && (acc_q < len_q) && (first_q || (pf_count_q != '0));
  assign accept    = ready && bus.mac_valid;
  assign pop       = accept && !first_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    psum_lane_add #(.W(W)) u_add (
      .a_i   (bus.mac_feature[g*W +: W]),
      .b_i   (head[g*W +: W]),
      .sum_o (sum_word[g*W +: W])
    );
  end

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    len_d    = len_q;
    first_d  = first_q;
    issued_d = issued_q + LEN_WIDTH'(pulse);
    acc_d    = acc_q + LEN_WIDTH'(accept);
    sr_d     = RD_LATENCY'({sr_q, pulse});
    refresh  = 1'b0;
    pass_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pass_start) begin
          len_d    = (pass_len == '0) ? LEN_WIDTH'(1) : pass_len;
          first_d  = first_pass;
          issued_d = '0;
          acc_d    = '0;
          flush_d  = 1'b0;
          refresh  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc_d == len_q) begin
          flush_d = 1'b0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // First FLUSH cycle shows the last write-back, second raises done.
        if (!flush_q) begin
          flush_d = 1'b1;
        end else begin
          pass_done = 1'b1;
          flush_d   = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flush_q    <= 1'b0;
      len_q      <= '0;
      first_q    <= 1'b0;
      issued_q   <= '0;
      acc_q      <= '0;
      sr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pf_count_q <= '0;
      feat_q     <= '0;
      fvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      len_q      <= len_d;
      first_q    <= first_d;
      issued_q   <= issued_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
      pf_count_q <= pf_count_q + CNT_W'(push) - CNT_W'(pop);
      fvalid_q   <= accept;
      if (accept) begin
        feat_q <= first_q ? bus.mac_feature : sum_word;
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.adder_feature;
    end
  end

  assign refresh_req       = refresh && !rst;
  assign pass_busy         = (state_q != ST_IDLE);
  assign bus.adder_pulse   = pulse;
  assign bus.mac_ready     = ready;
  assign bus.feature_in    = feat_q;
  assign bus.feature_valid = fvalid_q;

endmodule
